alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (operands `a`/`b`, 4-bit `ALUControl`, result plus `Zero`/`LessThan`/`LessThanUnsigned` flags) among NUM_REQ requesters. Each requester issues an operation through a valid/ready handshake. The block registers the winner's operands, drives the ALU for one cycle, captures the result and flags, and returns them tagged with the requester index. It sits between the requester units and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU among NUM_REQ requesters.
// Each operation is accepted, issued to the ALU for one cycle, and returned tagged with its owner.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]   req_ctrl,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [3:0]             alu_ctrl,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_zero,
    input  logic                   alu_lt,
    input  logic                   alu_ltu,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_lt,
    output logic                   rsp_ltu
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             lt_q, lt_d;
    logic             ltu_q, ltu_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   gnt_next;
    logic             accept;
    int               idx;

    // First valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
        gnt_next = IDW'((int'(gnt_id) + 1) % NUM_REQ);
    end

    // A new operation is taken when idle, or when the pending response drains this cycle.
    assign accept = rst_n && gnt_found &&
                    ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        res_d     = res_q;
        zero_d    = zero_q;
        lt_d      = lt_q;
        ltu_d     = ltu_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                lt_d    = alu_lt;
                ltu_d   = alu_ltu;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = accept ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            req_ready         = '0;
            req_ready[gnt_id] = 1'b1;
            a_d               = req_a[int'(gnt_id)*WIDTH +: WIDTH];
            b_d               = req_b[int'(gnt_id)*WIDTH +: WIDTH];
            ctrl_d            = req_ctrl[int'(gnt_id)*4 +: 4];
            id_d              = gnt_id;
            ptr_d             = gnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
        end
    end

    // Operand registers feed the ALU directly, so they hold the last issued op outside ISSUE.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_lt     = lt_q;
    assign rsp_ltu    = ltu_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small add/sub/slt ALU attached.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*4-1:0] req_ctrl;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic [3:0]     alu_ctrl;
    logic           alu_zero, alu_lt, alu_ltu;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero, rsp_lt, rsp_ltu;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt), .rsp_ltu(rsp_ltu)
    );

    always #5 clk = ~clk;

    // Shared ALU: 0 add, 1 sub, 2 signed set-less-than.
    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
        alu_lt   = $signed(alu_a) < $signed(alu_b);
        alu_ltu  = alu_a < alu_b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_ctrl[i*4 +: 4] = c;
    endtask

    // One isolated operation from an idle arbiter, rsp_ready held high.
    task automatic single_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [3:0] c, input logic [W-1:0] er,
                             input logic ez, input logic elt, input logic eltu);
        set_req(i, a, b, c);
        req_valid = 4'(1 << i);
        @(negedge clk);
        chk("op_ready", req_ready, 64'(1 << i));
        nxt();
        req_valid = '0;
        @(negedge clk);
        chk("op_alu_a", alu_a, a);
        chk("op_alu_b", alu_b, b);
        chk("op_alu_ctrl", alu_ctrl, c);
        chk("op_issue_novalid", rsp_valid, 0);
        nxt();
        @(negedge clk);
        chk("op_rsp_valid", rsp_valid, 1);
        chk("op_rsp_id", rsp_id, i);
        chk("op_rsp_result", rsp_result, er);
        chk("op_rsp_zero", rsp_zero, ez);
        chk("op_rsp_lt", rsp_lt, elt);
        chk("op_rsp_ltu", rsp_ltu, eltu);
        nxt();
    endtask

    logic [3:0] exp_rdy;
    logic       exp_v;
    int         eid;

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_a = '0;
        req_b = '0;
        req_ctrl = '0;
        for (int k = 0; k < N; k++) set_req(k, 32'(k + 10), 32'(k), 4'd0);
        nxt();
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        nxt();
        rst_n = 1'b1;

        // Rotation: all valid from ptr 0, grants 0,1,2,3,0 every other cycle.
        for (int c = 0; c <= 10; c++) begin
            if (c == 9) req_valid = '0;
            @(negedge clk);
            exp_rdy = (c % 2 == 0 && c <= 8) ? 4'(1 << ((c / 2) % 4)) : 4'h0;
            chk("rot_ready", req_ready, exp_rdy);
            exp_v = (c >= 2 && c % 2 == 0);
            chk("rot_valid", rsp_valid, exp_v);
            if (exp_v) begin
                eid = (c / 2 - 1) % 4;
                chk("rot_id", rsp_id, eid);
                chk("rot_result", rsp_result, 2 * eid + 10);
            end
            nxt();
        end

        single_op(0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b1, 1'b1);
        single_op(2, 32'd3, 32'd3, 4'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        single_op(2, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, 1'b0, 1'b1, 1'b0);

        // Wrap and skip: ptr is 3, only requesters 1 and 3 valid.
        set_req(1, 32'd7, 32'd2, 4'd1);
        set_req(3, 32'd9, 32'd4, 4'd0);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("wrap_ready0", req_ready, 4'b1000);
        nxt();
        @(negedge clk);
        chk("wrap_ready1", req_ready, 0);
        chk("wrap_alu_a1", alu_a, 9);
        nxt();
        @(negedge clk);
        chk("wrap_id3", rsp_id, 3);
        chk("wrap_res3", rsp_result, 13);
        chk("wrap_ready2", req_ready, 4'b0010);
        nxt();
        @(negedge clk);
        chk("wrap_ready3", req_ready, 0);
        chk("wrap_alu_a3", alu_a, 7);
        chk("wrap_alu_ctrl3", alu_ctrl, 1);
        nxt();
        req_valid = '0;
        @(negedge clk);
        chk("wrap_id1", rsp_id, 1);
        chk("wrap_res1", rsp_result, 5);
        chk("wrap_ready4", req_ready, 0);
        nxt();

        // Back-pressure: response held for 5 cycles, next grant when rsp_ready rises.
        rsp_ready = 1'b0;
        set_req(0, 32'd100, 32'd50, 4'd1);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("bp_ready0", req_ready, 4'b0001);
        nxt();
        @(negedge clk);
        chk("bp_ready1", req_ready, 0);
        nxt();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 50);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready_stall", req_ready, 0);
            nxt();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_release", req_ready, 4'b0001);
        chk("bp_valid_release", rsp_valid, 1);
        nxt();
        req_valid = '0;
        @(negedge clk);
        chk("bp_issue_novalid", rsp_valid, 0);
        nxt();
        @(negedge clk);
        chk("bp_valid2", rsp_valid, 1);
        chk("bp_result2", rsp_result, 50);
        nxt();

        // Reset during ISSUE aborts the op; ptr returns to 0.
        set_req(2, 32'd10, 32'd20, 4'd1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("mr_ready0", req_ready, 4'b0100);
        nxt();
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("mr_issue_alu_a", alu_a, 10);
        chk("mr_issue_ctrl", alu_ctrl, 1);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_alu_a", alu_a, 0);
        chk("mr_alu_b", alu_b, 0);
        chk("mr_alu_ctrl", alu_ctrl, 0);
        chk("mr_rsp_result", rsp_result, 0);
        chk("mr_rsp_id", rsp_id, 0);
        chk("mr_ready", req_ready, 0);
        nxt();
        req_valid = 4'b1100;
        @(negedge clk);
        chk("mr_first_grant", req_ready, 4'b0100);
        nxt();
        req_valid = '0;
        @(negedge clk);
        chk("mr_alu_a2", alu_a, 10);
        nxt();
        @(negedge clk);
        chk("mr_rsp_id2", rsp_id, 2);
        chk("mr_rsp_result2", rsp_result, 32'hFFFF_FFF6);
        chk("mr_rsp_lt2", rsp_lt, 1);
        chk("mr_rsp_ltu2", rsp_ltu, 1);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
